led_pattern_sequencer: RTL and testbench

Scheduler for the 4-LED bar output. It replaces the derived-clock blink counter with a single-clock design: a prescaler produces a one-cycle step enable, and a mode FSM selects one of three LED patterns. Two debounced push-buttons cycle the mode and pause/resume the sequence. Sits at the top level between board buttons and the led pins.

---
 rtl/led_seq_pkg.sv | 49 ++++
 rtl/led_pattern_sequencer_btn_debounce.sv | 44 ++++
 rtl/led_pattern_sequencer.sv | 84 ++++++++
 tb/tb_led_pattern_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// LED sequencer shared types: mode encoding, per-mode step counts, pattern tables.
// Latency: pure constants and combinational helper functions.
// Backpressure: none.
package led_seq_pkg;

   typedef enum logic [1:0] {
      MODE_BAR   = 2'd0,
      MODE_CHASE = 2'd1,
      MODE_BLINK = 2'd2
   } mode_e;

   localparam logic [2:0] BAR_STEPS   = 3'd5;
   localparam logic [2:0] CHASE_STEPS = 3'd4;
   localparam logic [2:0] BLINK_STEPS = 3'd2;

   // Entry [0] is step 0; bit 3 is the leftmost LED.
   localparam logic [4:0][3:0] BAR_PAT   = {4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
   localparam logic [3:0][3:0] CHASE_PAT = {4'b0001, 4'b0010, 4'b0100, 4'b1000};
   localparam logic [1:0][3:0] BLINK_PAT = {4'b1111, 4'b0000};

   function automatic logic [2:0] step_count(input mode_e m);
      case (m)
         MODE_BAR:   step_count = BAR_STEPS;
         MODE_CHASE: step_count = CHASE_STEPS;
         MODE_BLINK: step_count = BLINK_STEPS;
         default:    step_count = BAR_STEPS;
      endcase
   endfunction

   function automatic mode_e next_mode(input mode_e m);
      case (m)
         MODE_BAR:   next_mode = MODE_CHASE;
         MODE_CHASE: next_mode = MODE_BLINK;
         default:    next_mode = MODE_BAR;
      endcase
   endfunction

   // Out-of-range steps light nothing rather than aliasing into another entry.
   function automatic logic [3:0] pattern_lookup(input mode_e m, input logic [2:0] s);
      pattern_lookup = 4'b0000;
      case (m)
         MODE_BAR:   if (s < BAR_STEPS)   pattern_lookup = BAR_PAT[s];
         MODE_CHASE: if (s < CHASE_STEPS) pattern_lookup = CHASE_PAT[s[1:0]];
         MODE_BLINK: if (s < BLINK_STEPS) pattern_lookup = BLINK_PAT[s[0]];
         default:    pattern_lookup = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/led_pattern_sequencer_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, press pulse on debounced 0->1.
// Latency: clean edge to press pulse is 2+DEBOUNCE_CYC cycles; release gives no pulse.
// Backpressure: none; press is a single-cycle pulse the consumer must take.
module btn_debounce #(
   parameter int DEBOUNCE_CYC = 65536
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYC + 1);

   logic [1:0]    sync_q;
   logic          level_q;
   logic [CW-1:0] cnt_q;
   logic          synced;

   assign synced = sync_q[1];

   // Synchronize, then accept a new level only after it has held for DEBOUNCE_CYC cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= 2'b00;
         level_q <= 1'b0;
         cnt_q   <= '0;
         press   <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], btn};
         press  <= 1'b0;
         if (synced == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
            cnt_q   <= '0;
            level_q <= synced;
            press   <= synced;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

endmodule

// File: rtl/led_pattern_sequencer.sv
// 4-LED pattern sequencer: prescaled step enable, 3-mode pattern select, mode/pause buttons.
// Latency: led reflects a new (mode, step) one cycle after the tick or press that caused it.
// Backpressure: none; free-running, frozen only by the pause state.
module led_pattern_sequencer
   import led_seq_pkg::*;
#(
   parameter int TICK_DIV     = 8388608,
   parameter int DEBOUNCE_CYC = 65536,
   parameter int LED_W        = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn_mode,
   input  logic             btn_pause,
   output logic [LED_W-1:0] led,
   output logic [1:0]       mode,
   output logic             paused,
   output logic             tick
);

   localparam int PW = $clog2(TICK_DIV);

   logic [PW-1:0] presc_q, presc_nxt;
   logic [2:0]    step_q, step_nxt;
   mode_e         mode_q, mode_nxt;
   logic          paused_nxt;
   logic          mode_press, pause_press;

   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_mode (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_mode),
      .press (mode_press)
   );

   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_pause (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_pause),
      .press (pause_press)
   );

   assign tick = (presc_q == PW'(TICK_DIV - 1)) && !paused;
   assign mode = mode_q;

   // Next state: a mode press overrides any coincident tick; pause toggles independently.
   always_comb begin
      mode_nxt   = mode_q;
      step_nxt   = step_q;
      presc_nxt  = presc_q;
      paused_nxt = paused;
      if (mode_press) begin
         mode_nxt  = next_mode(mode_q);
         step_nxt  = 3'd0;
         presc_nxt = '0;
      end else if (!paused) begin
         if (tick) begin
            presc_nxt = '0;
            step_nxt  = (step_q == step_count(mode_q) - 3'd1) ? 3'd0 : step_q + 3'd1;
         end else begin
            presc_nxt = presc_q + PW'(1);
         end
      end
      if (pause_press) paused_nxt = !paused;
   end

   // Register state; led is looked up from next state so it lands with the step change.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q <= '0;
         step_q  <= 3'd0;
         mode_q  <= MODE_BAR;
         paused  <= 1'b0;
         led     <= '0;
      end else begin
         presc_q <= presc_nxt;
         step_q  <= step_nxt;
         mode_q  <= mode_nxt;
         paused  <= paused_nxt;
         led     <= LED_W'(pattern_lookup(mode_nxt, step_nxt));
      end
   end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with TICK_DIV=4, DEBOUNCE_CYC=3.
// Latency: each scenario starts from reset; cycle 0 is the first cycle after rst drops.
// Backpressure: none.
module tb_led_pattern_sequencer;

   logic       clk, rst, btn_mode, btn_pause;
   logic [3:0] led;
   logic [1:0] mode;
   logic       paused, tick;

   int n_checks = 0;
   int n_pass   = 0;

   localparam logic [3:0] BAR_EXP [6] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0000};

   led_pattern_sequencer #(.TICK_DIV(4), .DEBOUNCE_CYC(3), .LED_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_mode  (btn_mode),
      .btn_pause (btn_pause),
      .led       (led),
      .mode      (mode),
      .paused    (paused),
      .tick      (tick)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic do_reset();
      rst = 1'b1; btn_mode = 1'b0; btn_pause = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; btn_mode = 1'b1; btn_pause = 1'b1;
      @(posedge clk); @(posedge clk); #4;
      if (led !== 4'b0000) $display("FAIL reset_led got %b want 0000", led); else n_pass++;
      if (mode !== 2'd0) $display("FAIL reset_mode got %0d want 0", mode); else n_pass++;
      if (paused !== 1'b0) $display("FAIL reset_paused got %b want 0", paused); else n_pass++;
      if (tick !== 1'b0) $display("FAIL reset_tick got %b want 0", tick); else n_pass++;
      n_checks += 4;
   endtask

   task automatic test_bar_run();
      do_reset();
      for (int c = 0; c < 24; c++) begin
         #4;
         if (led !== BAR_EXP[c/4]) $display("FAIL bar_led c=%0d got %b want %b", c, led, BAR_EXP[c/4]); else n_pass++;
         if (tick !== (c % 4 == 3)) $display("FAIL bar_tick c=%0d got %b want %b", c, tick, (c % 4 == 3)); else n_pass++;
         if (mode !== 2'd0 || paused !== 1'b0) $display("FAIL bar_state c=%0d got mode=%0d paused=%b want 0/0", c, mode, paused); else n_pass++;
         n_checks += 3;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mode_press();
      logic [3:0] el;
      do_reset();
      for (int c = 0; c <= 20; c++) begin
         btn_mode = (c <= 5);
         if (c < 4) el = 4'b0000;
         else if (c < 10) el = 4'b1000;
         else if (c < 14) el = 4'b0100;
         else if (c < 18) el = 4'b0010;
         else el = 4'b0001;
         #4;
         if (mode !== ((c >= 6) ? 2'd1 : 2'd0)) $display("FAIL mp_mode c=%0d got %0d want %0d", c, mode, (c >= 6) ? 1 : 0); else n_pass++;
         if (led !== el) $display("FAIL mp_led c=%0d got %b want %b", c, led, el); else n_pass++;
         if (tick !== (c == 3 || c == 9 || c == 13 || c == 17)) $display("FAIL mp_tick c=%0d got %b", c, tick); else n_pass++;
         n_checks += 3;
         @(posedge clk); #1;
      end
      btn_mode = 1'b0;
   endtask

   task automatic test_glitch();
      do_reset();
      for (int c = 0; c < 16; c++) begin
         btn_mode = (c < 2);
         #4;
         if (mode !== 2'd0) $display("FAIL gl_mode c=%0d got %0d want 0", c, mode); else n_pass++;
         if (led !== BAR_EXP[c/4]) $display("FAIL gl_led c=%0d got %b want %b", c, led, BAR_EXP[c/4]); else n_pass++;
         if (tick !== (c % 4 == 3)) $display("FAIL gl_tick c=%0d got %b", c, tick); else n_pass++;
         n_checks += 3;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_pause();
      logic [3:0] el;
      do_reset();
      for (int c = 0; c <= 45; c++) begin
         btn_mode  = (c <= 5);
         btn_pause = (c >= 10 && c <= 15) || (c >= 36 && c <= 41);
         if (c < 4) el = 4'b0000;
         else if (c < 10) el = 4'b1000;
         else if (c < 14) el = 4'b0100;
         else if (c < 44) el = 4'b0010;
         else el = 4'b0001;
         #4;
         if (paused !== (c >= 16 && c <= 41)) $display("FAIL pz_paused c=%0d got %b", c, paused); else n_pass++;
         if (led !== el) $display("FAIL pz_led c=%0d got %b want %b", c, led, el); else n_pass++;
         if (tick !== (c == 3 || c == 9 || c == 13 || c == 43)) $display("FAIL pz_tick c=%0d got %b", c, tick); else n_pass++;
         n_checks += 3;
         @(posedge clk); #1;
      end
      btn_mode = 1'b0; btn_pause = 1'b0;
   endtask

   task automatic test_mode_tick_collision();
      logic [3:0] el;
      logic [1:0] em;
      do_reset();
      for (int c = 0; c <= 36; c++) begin
         btn_mode = (c <= 5) || (c >= 12 && c <= 17) || (c >= 24 && c <= 29);
         if (c < 6) em = 2'd0; else if (c < 18) em = 2'd1; else if (c < 30) em = 2'd2; else em = 2'd0;
         if (c < 4) el = 4'b0000;
         else if (c < 10) el = 4'b1000;
         else if (c < 14) el = 4'b0100;
         else if (c < 18) el = 4'b0010;
         else if (c < 22) el = 4'b0000;
         else if (c < 26) el = 4'b1111;
         else if (c < 34) el = 4'b0000;
         else el = 4'b1000;
         #4;
         if (mode !== em) $display("FAIL co_mode c=%0d got %0d want %0d", c, mode, em); else n_pass++;
         if (led !== el) $display("FAIL co_led c=%0d got %b want %b", c, led, el); else n_pass++;
         if (tick !== (c == 3 || c == 9 || c == 13 || c == 17 || c == 21 || c == 25 || c == 29 || c == 33))
            $display("FAIL co_tick c=%0d got %b", c, tick);
         else n_pass++;
         n_checks += 3;
         @(posedge clk); #1;
      end
      btn_mode = 1'b0;
   endtask

   task automatic test_both_press();
      do_reset();
      for (int c = 0; c <= 14; c++) begin
         btn_mode  = (c <= 5);
         btn_pause = (c <= 5);
         #4;
         if (mode !== ((c >= 6) ? 2'd1 : 2'd0)) $display("FAIL bp_mode c=%0d got %0d", c, mode); else n_pass++;
         if (paused !== (c >= 6)) $display("FAIL bp_paused c=%0d got %b", c, paused); else n_pass++;
         if (led !== ((c < 4) ? 4'b0000 : 4'b1000)) $display("FAIL bp_led c=%0d got %b", c, led); else n_pass++;
         if (tick !== (c == 3)) $display("FAIL bp_tick c=%0d got %b", c, tick); else n_pass++;
         n_checks += 4;
         @(posedge clk); #1;
      end
      btn_mode = 1'b0; btn_pause = 1'b0;
   endtask

   task automatic test_mid_reset();
      int d;
      do_reset();
      for (int c = 0; c <= 30; c++) begin
         rst       = (c == 9);
         btn_pause = (c >= 6 && c <= 9);
         d = (c <= 9) ? c : c - 10;
         #4;
         if (led !== BAR_EXP[d/4]) $display("FAIL mr_led c=%0d got %b want %b", c, led, BAR_EXP[d/4]); else n_pass++;
         if (tick !== (d % 4 == 3)) $display("FAIL mr_tick c=%0d got %b", c, tick); else n_pass++;
         if (paused !== 1'b0 || mode !== 2'd0) $display("FAIL mr_state c=%0d got paused=%b mode=%0d want 0/0", c, paused, mode); else n_pass++;
         n_checks += 3;
         @(posedge clk); #1;
      end
      rst = 1'b0; btn_pause = 1'b0;
   endtask

   initial begin
      rst = 1'b1; btn_mode = 1'b0; btn_pause = 1'b0;
      test_reset();
      test_bar_run();
      test_mode_press();
      test_glitch();
      test_pause();
      test_mode_tick_collision();
      test_both_press();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
